lzc_arbiter: RTL and testbench
==============================

LZC_ARBITER -- requirements
Module: lzc_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk  input  1  sole clock, all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 req_valid  input  4  per-requester request valid, bit i = requester i.
REQ-004 req_data  input  64  per-requester 16-bit operands, requester i on bits [16i+15:16i].
REQ-005 req_ready  output  4  per-requester accept, one-hot or zero.
REQ-006 rsp_valid  output  1  response valid.
REQ-007 rsp_ready  input  1  response consumer ready.
REQ-008 rsp_id  output  2  index of the requester that owns the response.
REQ-009 rsp_count  output  5  leading-zero count of the accepted operand, 0..16.
REQ-010 rsp_zero  output  1  accepted operand was all-zero.

Function
REQ-011 The block SHALL contain exactly one sixteen_bit_LZC instance, shared by all four requesters; that instance's output register has one cycle of latency and no enable.
REQ-012 can_issue = !rsp_valid | rsp_ready; an accept occurs in a cycle when can_issue and at least one req_valid bit is high.
REQ-013 req_ready[i] SHALL be high only for the granted requester and only while can_issue; req_ready may depend combinationally on req_valid and rsp_ready.
REQ-014 Default arbitration is round-robin: search starts at last_grant+1 modulo 4, and the first requester with req_valid high is granted.
REQ-015 last_grant SHALL update to the granted index only on an accept; it holds when there is no accept or when output is stalled.
REQ-016 On an accept, the granted operand SHALL drive the LZC input and be captured into a 16-bit hold register; the grant index goes to the rsp_id register and the all-zero test of the operand goes to the rsp_zero register.
REQ-017 In cycles with no accept, the LZC input SHALL be the hold register, so rsp_count stays stable while stalled.
REQ-018 Latency: the response SHALL appear with rsp_valid high in the cycle after the accept; throughput is one response per cycle when rsp_ready stays high.
REQ-019 rsp_valid next-state: set on an accept; cleared when rsp_ready is high with no accept; held otherwise.
REQ-020 rsp_count SHALL be {1'b0, LZC value} when rsp_zero is low and 5'd16 when rsp_zero is high; the LZC value of 15 for zero input is overridden.
REQ-021 rsp_id, rsp_count and rsp_zero SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-022 Simultaneous rsp_ready and new request: the old response completes and the new one is accepted in the same cycle (back-to-back).
REQ-023 A requester that drops req_valid before it is accepted loses no state; its next request is not affected.

Reset
REQ-024 While rst_n is low: rsp_valid=0, rsp_id=0, rsp_zero=0, hold register=0, last_grant=3 (requester 0 has first priority after reset), req_ready=0.
REQ-025 rsp_count after reset SHALL be valid no later than the first clock edge after release; it reads 5'd16 once the LZC has taken in the zero hold register.
REQ-026 A reset asserted mid-transfer SHALL discard the in-flight response; no response is produced after release.

Configuration
REQ-027 Macro LZC_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (requester 0 highest, 3 lowest) and last_grant SHALL be removed; when not defined, the round-robin rules REQ-014/015 apply.

Verification
REQ-028 Single request: req_valid=4'b0100, data2=16'h00F0 -> req_ready=4'b0100 in that cycle; the next cycle gives rsp_valid=1, rsp_id=2, rsp_count=8, rsp_zero=0.
REQ-029 Zero operand: data0=16'h0000 -> rsp_count=16, rsp_zero=1. Operand 16'h8000 -> rsp_count=0. Operand 16'h0001 -> rsp_count=15.
REQ-030 Round-robin: all four valid continuously with rsp_ready=1 -> grants in the order 0,1,2,3,0 over consecutive cycles, with one response per cycle. With LZC_ARB_FIXED_PRIO_EN defined -> grants are 0,0,0,...
REQ-031 Backpressure: a response is pending and rsp_ready=0 for 5 cycles while req_valid=4'hF -> req_ready=0, and rsp_id, rsp_count and rsp_zero are unchanged. Raising rsp_ready -> the next grant is accepted in the same cycle.
REQ-032 Reset mid-operation: rst_n is pulled low while rsp_valid=1 -> rsp_valid=0 at once. After release with requesters 0 and 3 valid -> requester 0 is granted first.

Source files
------------

// File: rtl/lzc_arbiter.sv
// Four-requester arbiter sharing one registered 16-bit leading-zero counter.
// Optional macro LZC_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.

module sixteen_bit_LZC (
  input  logic        clk,
  input  logic [15:0] din,
  output logic [3:0]  count,
  output logic        zero
);

  logic [3:0] cnt_c;
  logic       found;

  // An all-zero input yields 15 here; the zero flag lets the caller override it.
  always_comb begin
    cnt_c = 4'd15;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!found && din[15-i]) begin
        cnt_c = 4'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    count <= cnt_c;
    zero  <= ~|din;
  end

endmodule

module lzc_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_data,
  output logic [3:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [4:0]  rsp_count,
  output logic        rsp_zero
);

  typedef enum logic {S_IDLE, S_RSP} state_t;

  state_t      state, state_nxt;
  logic        can_issue;
  logic        accept;
  logic [1:0]  grant;
  logic        grant_found;
  logic [15:0] hold;
  logic [15:0] lzc_in;
  logic [3:0]  lzc_cnt;
  logic        lzc_zero;

  assign can_issue = (state == S_IDLE) | rsp_ready;

`ifdef LZC_ARB_FIXED_PRIO_EN
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!grant_found && req_valid[2'(k)]) begin
        grant       = 2'(k);
        grant_found = 1'b1;
      end
    end
  end
`else
  logic [1:0] last_grant;
  logic [1:0] idx;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = last_grant + 2'(k + 1);
      if (!grant_found && req_valid[idx]) begin
        grant       = idx;
        grant_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  // Gating with rst_n keeps req_ready low while reset is held.
  assign accept    = rst_n & can_issue & grant_found;
  assign req_ready = accept ? (4'b0001 << grant) : '0;
  assign lzc_in    = accept ? req_data[{grant, 4'h0} +: 16] : hold;

  sixteen_bit_LZC u_lzc (
    .clk   (clk),
    .din   (lzc_in),
    .count (lzc_cnt),
    .zero  (lzc_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_RSP;
      S_RSP: begin
        if (accept) begin
          state_nxt = S_RSP;
        end else if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == S_RSP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      rsp_id   <= '0;
      rsp_zero <= 1'b0;
    end else if (accept) begin
      hold     <= lzc_in;
      rsp_id   <= grant;
      rsp_zero <= ~|lzc_in;
    end
  end

  // lzc_zero covers the post-reset case where the zero hold register is counted.
  assign rsp_count = (rsp_zero | lzc_zero) ? 5'd16 : {1'b0, lzc_cnt};

endmodule

// File: tb/tb_lzc_arbiter.sv
// Directed self-checking bench for lzc_arbiter (default round-robin build).

module tb_lzc_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_count;
  logic        rsp_zero;

  int checks = 0;
  int errors = 0;

  lzc_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .rsp_zero  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [4:0] cnt,
                           input logic zero);
    check({tag, " valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " id"},    32'(rsp_id),    32'(id));
    check({tag, " count"}, 32'(rsp_count), 32'(cnt));
    check({tag, " zero"},  32'(rsp_zero),  32'(zero));
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests pending to prove req_ready is gated.
    repeat (3) next();
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst rsp_id",    32'(rsp_id),    32'h0);
    check("rst rsp_zero",  32'(rsp_zero),  32'h0);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    next();
    check("post-rst count", 32'(rsp_count), 32'd16);
    check("post-rst valid", 32'(rsp_valid), 32'd0);

    // Single request from requester 2.
    req_data[47:32] = 16'h00F0;
    req_valid       = 4'b0100;
    #1 check("single req_ready", 32'(req_ready), 32'b0100);
    next();
    check_rsp("single", 2'd2, 5'd8, 1'b0);
    req_valid = 4'h0;
    next();
    check("single drain", 32'(rsp_valid), 32'd0);

    // Requester 0 back-to-back: zero, MSB set, LSB only.
    req_data[15:0] = 16'h0000;
    req_valid      = 4'b0001;
    #1 check("zero req_ready", 32'(req_ready), 32'b0001);
    next();
    check_rsp("zero op", 2'd0, 5'd16, 1'b1);
    req_data[15:0] = 16'h8000;
    next();
    check_rsp("msb op", 2'd0, 5'd0, 1'b0);
    req_data[15:0] = 16'h0001;
    next();
    check_rsp("lsb op", 2'd0, 5'd15, 1'b0);
    req_valid = 4'h0;
    next();
    check("lsb drain", 32'(rsp_valid), 32'd0);

    // Requester 3 alone so round-robin then starts at 0.
    req_data  = {16'h0001, 16'h0F00, 16'h4000, 16'h0080};
    req_valid = 4'b1000;
    next();
    check_rsp("req3", 2'd3, 5'd15, 1'b0);
    req_valid = 4'h0;
    next();

    // All four valid: grants 0,1,2,3,0 with one response per cycle.
    req_valid = 4'hF;
    #1 check("rr grant0", 32'(req_ready), 32'b0001);
    next();
    check_rsp("rr rsp0", 2'd0, 5'd8, 1'b0);
    #1 check("rr grant1", 32'(req_ready), 32'b0010);
    next();
    check_rsp("rr rsp1", 2'd1, 5'd1, 1'b0);
    #1 check("rr grant2", 32'(req_ready), 32'b0100);
    next();
    check_rsp("rr rsp2", 2'd2, 5'd4, 1'b0);
    #1 check("rr grant3", 32'(req_ready), 32'b1000);
    next();
    check_rsp("rr rsp3", 2'd3, 5'd15, 1'b0);
    #1 check("rr grant0b", 32'(req_ready), 32'b0001);
    next();
    check_rsp("rr rsp0b", 2'd0, 5'd8, 1'b0);

    // Backpressure for 5 cycles: nothing accepted, response frozen.
    rsp_ready = 1'b0;
    #1 check("bp req_ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      next();
      check("bp stall req_ready", 32'(req_ready), 32'h0);
      check_rsp("bp stall", 2'd0, 5'd8, 1'b0);
    end
    rsp_ready = 1'b1;
    #1 check("bp release grant", 32'(req_ready), 32'b0010);
    next();
    check_rsp("bp release rsp", 2'd1, 5'd1, 1'b0);

    // Reset while a response is pending.
    rsp_ready = 1'b0;
    req_valid = 4'h0;
    #1 check_rsp("pre-rst pending", 2'd1, 5'd1, 1'b0);
    rst_n = 1'b0;
    #1 check("midrst valid", 32'(rsp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'h0);
    next();
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    next();
    check("post-midrst no rsp", 32'(rsp_valid), 32'd0);
    req_data[15:0] = 16'h0100;
    req_valid      = 4'b1001;
    #1 check("post-midrst grant", 32'(req_ready), 32'b0001);
    next();
    check_rsp("post-midrst rsp", 2'd0, 5'd7, 1'b0);
    req_valid = 4'h0;
    next();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
